// File: rtl/exe_branch_unit.sv
// Execute-stage ALU and branch comparator plus a direct-mapped branch target buffer for fetch.
// The ALU and comparator are purely combinational; only the BTB holds state.
module exe_branch_unit #(
  parameter int unsigned BTB_INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  aluop,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_f,
  input  logic [2:0]  cmpop,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  output logic        br_en,
  input  logic        btb_read,
  input  logic [31:0] btb_pc,
  input  logic [31:0] btb_ins,
  output logic [31:0] btb_target,
  output logic        btb_resp
);

  localparam int unsigned Entries = 1 << BTB_INDEX_BITS;
  localparam int unsigned TagW    = 32 - BTB_INDEX_BITS - 2;

  always_comb begin
    alu_f = '0;
    unique case (aluop)
      3'b000: alu_f = alu_a + alu_b;
      3'b001: alu_f = alu_a << alu_b[4:0];
      3'b010: alu_f = $signed(alu_a) >>> alu_b[4:0];
      3'b011: alu_f = alu_a - alu_b;
      3'b100: alu_f = alu_a ^ alu_b;
      3'b101: alu_f = alu_a >> alu_b[4:0];
      3'b110: alu_f = alu_a | alu_b;
      3'b111: alu_f = alu_a & alu_b;
      default: alu_f = '0;
    endcase
  end

  always_comb begin
    br_en = 1'b0;
    unique case (cmpop)
      3'b000: br_en = (cmp_a == cmp_b);
      3'b001: br_en = (cmp_a != cmp_b);
      3'b100: br_en = ($signed(cmp_a) < $signed(cmp_b));
      3'b101: br_en = ($signed(cmp_a) >= $signed(cmp_b));
      3'b110: br_en = (cmp_a < cmp_b);
      3'b111: br_en = (cmp_a >= cmp_b);
      default: br_en = 1'b0;
    endcase
  end

  logic [Entries-1:0]        valid_q, valid_d;
  logic [TagW-1:0]           tag_q    [Entries];
  logic [31:0]               target_q [Entries];
  logic [BTB_INDEX_BITS-1:0] index;
  logic [TagW-1:0]           tag;
  logic [31:0]               b_imm;
  logic                      hit;
  logic                      fill;

  assign index = btb_pc[BTB_INDEX_BITS+1:2];
  assign tag   = btb_pc[31:BTB_INDEX_BITS+2];
  assign b_imm = {{19{btb_ins[31]}}, btb_ins[31], btb_ins[7], btb_ins[30:25], btb_ins[11:8], 1'b0};

  // Opcode, register and funct3 fields play no part in the target.
  logic unused_ins;
  assign unused_ins = ^{btb_ins[24:12], btb_ins[6:0]};

  assign hit        = btb_read & valid_q[index] & (tag_q[index] == tag);
  assign fill       = btb_read & ~hit & ~reset;
  assign btb_resp   = hit & ~reset;
  assign btb_target = target_q[index];

  always_comb begin
    valid_d = valid_q;
    if (reset) begin
      valid_d = '0;
    end else if (fill) begin
      valid_d[index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  // Tag/target storage is left unreset; valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[index]    <= tag;
      target_q[index] <= btb_pc + b_imm;
    end
  end

endmodule

// File: tb/tb_exe_branch_unit.sv
// Directed self-checking bench for exe_branch_unit: ALU, comparator and BTB fill/hit/alias/reset.
module tb_exe_branch_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  aluop;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [2:0]  cmpop;
  logic [31:0] cmp_a, cmp_b;
  logic        br_en;
  logic        btb_read;
  logic [31:0] btb_pc, btb_ins, btb_target;
  logic        btb_resp;

  int checks;
  int failures;

  localparam logic [31:0] InsBeq8  = 32'h0020_8463;
  localparam logic [31:0] InsNeg4  = 32'hFE20_8EE3;

  exe_branch_unit #(.BTB_INDEX_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .aluop      (aluop),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .cmpop      (cmpop),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .br_en      (br_en),
    .btb_read   (btb_read),
    .btb_pc     (btb_pc),
    .btb_ins    (btb_ins),
    .btb_target (btb_target),
    .btb_resp   (btb_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btb_read = 1'b1; btb_pc = 32'h60; btb_ins = InsBeq8;
    aluop = 3'b000; alu_a = 32'd3; alu_b = 32'd4;
    tick(); tick();
    checks++;
    if (btb_resp !== 1'b0) begin
      failures++; $display("FAIL reset_resp got=%b want=0", btb_resp);
    end
    checks++;
    if (alu_f !== 32'd7) begin
      failures++; $display("FAIL reset_alu got=%h want=00000007", alu_f);
    end
    btb_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    logic [31:0] exp [8];
    exp[0] = 32'h0000_0014; exp[1] = 32'hFFFF_FF00; exp[2] = 32'hFFFF_FFFF;
    exp[3] = 32'hFFFF_FFCC; exp[4] = 32'hFFFF_FFD4; exp[5] = 32'h0FFF_FFFF;
    exp[6] = 32'hFFFF_FFF4; exp[7] = 32'h0000_0020;
    alu_a = 32'hFFFF_FFF0; alu_b = 32'h0000_0024;
    for (int i = 0; i < 8; i++) begin
      aluop = 3'(i);
      #1;
      checks++;
      if (alu_f !== exp[i]) begin
        failures++; $display("FAIL alu_op%0d got=%h want=%h", i, alu_f, exp[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [2:0] ops  [9];
    logic       exp  [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    ops[0]=3'b000; exp[0]=1'b0; ops[1]=3'b001; exp[1]=1'b1; ops[2]=3'b100; exp[2]=1'b1;
    ops[3]=3'b101; exp[3]=1'b0; ops[4]=3'b110; exp[4]=1'b0; ops[5]=3'b111; exp[5]=1'b1;
    ops[6]=3'b010; exp[6]=1'b0;
    for (int i = 0; i < 7; i++) begin as[i] = 32'hFFFF_FFFF; bs[i] = 32'h1; end
    ops[7]=3'b000; exp[7]=1'b1; as[7]=32'd5; bs[7]=32'd5;
    ops[8]=3'b101; exp[8]=1'b1; as[8]=32'd5; bs[8]=32'd5;
    for (int i = 0; i < 9; i++) begin
      cmpop = ops[i]; cmp_a = as[i]; cmp_b = bs[i];
      #1;
      checks++;
      if (br_en !== exp[i]) begin
        failures++; $display("FAIL cmp_vec%0d op=%b got=%b want=%b", i, ops[i], br_en, exp[i]);
      end
    end
    cmpop = 3'b111; cmp_a = 32'd5; cmp_b = 32'd5;
    #1;
    checks++;
    if (br_en !== 1'b1) begin
      failures++; $display("FAIL cmp_bgeu_eq got=%b want=1", br_en);
    end
  endtask

  // Miss then hit on the following cycle with the expected target.
  task automatic miss_then_hit(input string name, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] tgt);
    btb_read = 1'b1; btb_pc = pc; btb_ins = ins;
    #1;
    checks++;
    if (btb_resp !== 1'b0) begin
      failures++; $display("FAIL %s_miss resp got=%b want=0", name, btb_resp);
    end
    tick();
    checks++;
    if (btb_resp !== 1'b1 || btb_target !== tgt) begin
      failures++;
      $display("FAIL %s_hit resp=%b target=%h want resp=1 target=%h", name, btb_resp, btb_target, tgt);
    end
  endtask

  task automatic test_btb_fill();
    miss_then_hit("cold", 32'h60, InsBeq8, 32'h68);
    btb_read = 1'b0;
    #1;
    checks++;
    if (btb_resp !== 1'b0) begin
      failures++; $display("FAIL idle_resp got=%b want=0", btb_resp);
    end
    tick(); tick();
    btb_read = 1'b1;
    #1;
    checks++;
    if (btb_resp !== 1'b1 || btb_target !== 32'h68) begin
      failures++; $display("FAIL rehit resp=%b target=%h want resp=1 target=00000068", btb_resp, btb_target);
    end
    tick();
  endtask

  task automatic test_neg_offset();
    miss_then_hit("neg", 32'h100, InsNeg4, 32'hFC);
    btb_read = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    miss_then_hit("alias_a0", 32'hA0, InsBeq8, 32'hA8);
    miss_then_hit("alias_60", 32'h60, InsBeq8, 32'h68);
    btb_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    miss_then_hit("post_reset", 32'h60, InsBeq8, 32'h68);
    btb_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_fill();
    reset = 1'b1; btb_read = 1'b1; btb_pc = 32'h100; btb_ins = InsNeg4;
    #1;
    checks++;
    if (btb_resp !== 1'b0) begin
      failures++; $display("FAIL rst_fill_resp got=%b want=0", btb_resp);
    end
    tick();
    reset = 1'b0;
    miss_then_hit("rst_fill", 32'h100, InsNeg4, 32'hFC);
    btb_read = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; btb_read = 1'b0; btb_pc = '0; btb_ins = '0;
    aluop = '0; alu_a = '0; alu_b = '0; cmpop = '0; cmp_a = '0; cmp_b = '0;
    test_reset();
    test_alu();
    test_cmp();
    test_btb_fill();
    test_neg_offset();
    test_alias();
    test_reset_mid();
    test_reset_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_branch_unit.md
Name: exe_branch_unit

Overview:
Combined execute-stage datapath and fetch-stage branch target buffer for the 5-stage RV32I pipeline.
- ALU and comparator: purely combinational; serve EXE (ALU result, branch/slt decision).
- BTB: clocked; serves IF with the taken-branch target for a fetched conditional branch; fetch stalls until btb_resp.

Parameters:
BTB_INDEX_BITS, 4, log2 of BTB entry count (16 entries, direct-mapped); index = btb_pc[BTB_INDEX_BITS+1:2], tag = btb_pc[31:BTB_INDEX_BITS+2].

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high; invalidates all BTB entries
aluop  input  3  ALU operation (encoding below)
alu_a  input  32  ALU operand A
alu_b  input  32  ALU operand B
alu_f  output  32  ALU result
cmpop  input  3  comparator op, branch funct3 encoding
cmp_a  input  32  comparator operand A
cmp_b  input  32  comparator operand B
br_en  output  1  comparison result
btb_read  input  1  lookup request (IF instruction is a branch and I-mem responded)
btb_pc  input  32  PC of the fetched branch
btb_ins  input  32  fetched branch instruction word
btb_target  output  32  predicted taken target
btb_resp  output  1  btb_target valid this cycle

Behaviour:
ALU, combinational; 32-bit, wrap-around, no flags:
- 000 add: a+b
- 001 sll: a << b[4:0]
- 010 sra: $signed(a) >>> b[4:0]
- 011 sub: a-b
- 100 xor
- 101 srl: a >> b[4:0]
- 110 or
- 111 and
- Only b[4:0] used for shifts.

Comparator, combinational:
- 000 beq: a==b
- 001 bne: a!=b
- 100 blt: signed <
- 101 bge: signed >=
- 110 bltu: unsigned <
- 111 bgeu: unsigned >=
- 010, 011: br_en = 0.

BTB:
- Entry = valid bit, tag, 32-bit target.
- B-immediate = sign-extend {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}.
- Target = btb_pc + B-imm, mod 2^32.

Lookup, combinational: hit = btb_read & valid[index] & tag match.
- Hit: btb_resp = 1 same cycle; btb_target = stored target.
- btb_read = 0: btb_resp = 0; btb_target = stored target at index (don't-care).

Miss (btb_read & !hit):
- btb_resp = 0.
- At next rising edge: entry[index] <= {1, tag, btb_pc + B-imm}.
- If btb_read is held with same PC, next cycle hits and responds. Miss latency = 1 extra cycle; hit latency = 0.
- Conflicting PC with same index overwrites the old entry (direct-mapped replacement).

No writes occur when btb_read = 0.

Reset:
- All valid bits cleared at the rising edge with reset = 1; btb_resp = 0 that cycle.
- Reset has priority over a simultaneous miss fill; no entry is written.
- Target/tag storage need not be reset.

ALU and comparator are unaffected by clk and reset.

Test Plan:
1. ALU: a=0xFFFFFFF0, b=0x00000024 → add=0x00000014, sub=0xFFFFFFCC, sll=0xFFFFFF00, srl=0x0FFFFFFF, sra=0xFFFFFFFF, xor=0xFFFFFFD4, or=0xFFFFFFF4, and=0x00000020.
2. Comparator: a=0xFFFFFFFF, b=0x00000001 → beq 0, bne 1, blt 1, bge 0, bltu 0, bgeu 1; cmpop 010 → 0; a=b=5 → beq 1, bge 1, bgeu 1.
3. BTB cold miss then hit: after reset, btb_read=1, pc=0x00000060, ins=0x00208463 (beq, imm +8) → resp 0 in cycle 0; resp 1 with target 0x00000068 in cycle 1; re-read later hits with 0 latency.
4. Negative offset: pc=0x00000100, ins=0xFE208EE3 (imm −4) → after fill, target 0x000000FC.
5. Aliasing: fill pc=0x00000060, then pc=0x000000A0 (same index, different tag) → miss, refill. Re-read 0x60 → miss again.
6. Reset mid-operation: entry valid, pulse reset for one cycle → next read of same PC misses (resp 0) then hits one cycle later. Reset coinciding with a miss → no entry installed.
